rvb_shifter_issue: RTL
======================

Name: rvb_shifter_issue

Overview:
- Initiator-side issue/writeback sequencer for the bitmanip shift unit.
- Accepts a decoded-stage instruction word plus operands from the core pipeline and extracts the control bits the shift unit consumes (insn bits 3/12/14/26/27/29/30).
- Drives the unit's valid/ready request handshake, collects its result, and returns an in-order writeback tagged with the destination register.
- Non-shifter encodings never reach the unit; they are returned in order with an illegal flag.

Parameters:
- XLEN, 64, datapath width (32 or 64).
- DEPTH, 4, ordering FIFO entries (power of two, ≥2); bounds accepted-but-not-written-back ops.

Ports:
- clock  in  1  positive-edge clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  pipeline offers an instruction
- in_ready  out  1  block accepts it
- in_insn  in  32  instruction word
- in_rs1, in_rs2, in_rs3  in  XLEN each  register operands
- unit_valid  out  1  request to shift unit
- unit_ready  in  1  shift unit accepts request
- unit_rs1, unit_rs2, unit_rs3  out  XLEN each  operands to unit
- unit_insn3, unit_insn12, unit_insn14, unit_insn26, unit_insn27, unit_insn29, unit_insn30  out  1 each  control bits to unit
- unit_dout_valid  in  1  unit result valid
- unit_dout_ready  out  1  block accepts result
- unit_dout_rd  in  XLEN  unit result
- wb_valid  out  1  writeback valid
- wb_ready  in  1  register file accepts writeback
- wb_rd_idx  out  5  destination register
- wb_value  out  XLEN  result (0 when illegal)
- wb_illegal  out  1  op was not a shifter encoding

Behaviour:
- Legality is decided on in_insn:
  - opcode[6:0] must be one of 0010011, 0110011, 0011011, 0111011;
  - funct3 [14:12] must be 001 or 101;
  - any other encoding is illegal;
  - XLEN==32 with insn[3]=1 is illegal.
- Operand rs2: register form (insn[5]=1) passes in_rs2; immediate form (insn[5]=0) substitutes zero-extended insn[25:20].
- Accept: in_ready = (fifo_count < DEPTH) && (!req_valid || unit_ready). On accept, push {rd=insn[11:7], illegal} into the ordering FIFO.
  - Legal ops also load the request register (operands and control bits) and set req_valid.
  - Illegal ops push the FIFO only.
- Request: unit_valid = req_valid. All unit_* outputs are held stable while unit_valid && !unit_ready. req_valid clears on handshake unless reloaded the same cycle.
- Response/writeback: the writeback register loads when it is empty or wb_ready=1 (wb_free), then pops the FIFO head.
  - Head legal: unit_dout_ready = wb_free && head legal. On handshake, wb_value=unit_dout_rd, wb_illegal=0.
  - Head illegal: loads with wb_value=0, wb_illegal=1, without waiting for the unit.
  - wb_valid holds, with its data stable, until wb_ready.
- Latency:
  - Legal op accepted at cycle N → unit_valid at N+1 → wb_valid at N+2, given a same-cycle unit and wb_ready=1.
  - Illegal op: wb_valid at N+2 when the FIFO was empty; otherwise it follows strict order.
  - Sustained throughput: 1 op/cycle.
- Ordering: writebacks leave strictly in acceptance order; an illegal op never overtakes an earlier legal op.
- FIFO full: in_ready=0. FIFO pointers wrap modulo DEPTH. Push and pop in the same cycle at full is allowed only via the in_ready equation, which never accepts at full.
- Backpressure chain: wb_ready=0 → unit_dout_ready=0 → unit stalls unit_ready → request held → in_ready=0.
- Reset (asynchronous, any time):
  - req_valid, wb_valid, fifo_count, pointers → 0;
  - unit_valid=0, unit_dout_ready=0, wb_illegal=0, wb_value=0, wb_rd_idx=0;
  - in_ready=1 after release;
  - in-flight operations are discarded.

Optional Feature:
- RVB_SHIFTER_ISSUE_PERF_EN defined adds three 32-bit outputs, all reset to 0, all wrapping at 2^32:
  - perf_issued: unit request handshakes;
  - perf_illegal: illegal ops accepted;
  - perf_stall: cycles with in_valid && !in_ready.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold resetn=0 mid-stream with 3 ops queued → all valids 0, in_ready=1 after release, no stale writeback ever appears.
- SLLI x5,x1,3 (in_insn=0x00309293), in_rs1=0x1, real shift unit attached → unit_rs2=3, unit_insn12=1, unit_insn14=0; two cycles later wb_valid=1, wb_rd_idx=5, wb_value=0x8.
- ADD x7 (in_insn=0x000003B3) → unit_valid never asserts; wb_valid with wb_rd_idx=7, wb_illegal=1, wb_value=0.
- Back-to-back SLL x3 (rs1=1, rs2=4), ADD x7, SRL x4 (rs1=0x100, rs2=4) → writebacks in order: (3, 0x10, 0), (7, 0, 1), (4, 0x10, 0).
- wb_ready=0 for 12 cycles with in_valid=1 continuously → in_ready deasserts after the FIFO holds 4 entries; on release, all ops are written back in order, none lost or duplicated.
- unit_ready toggled randomly for 1000 ops → unit_* outputs stable during stalls; results match the software model.

Source files
------------

// File: rtl/rvb_shifter_issue.sv
// Issue/writeback sequencer for the bitmanip shift unit: decodes, issues, returns in-order writebacks.
// Define RVB_SHIFTER_ISSUE_PERF_EN to add the perf_issued/perf_illegal/perf_stall counters.
module rvb_shifter_issue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rs3,
  output logic            unit_valid,
  input  logic            unit_ready,
  output logic [XLEN-1:0] unit_rs1,
  output logic [XLEN-1:0] unit_rs2,
  output logic [XLEN-1:0] unit_rs3,
  output logic            unit_insn3,
  output logic            unit_insn12,
  output logic            unit_insn14,
  output logic            unit_insn26,
  output logic            unit_insn27,
  output logic            unit_insn29,
  output logic            unit_insn30,
  input  logic            unit_dout_valid,
  output logic            unit_dout_ready,
  input  logic [XLEN-1:0] unit_dout_rd,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd_idx,
  output logic [XLEN-1:0] wb_value,
  output logic            wb_illegal
`ifdef RVB_SHIFTER_ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_illegal,
  output logic [31:0]     perf_stall
`endif
);

  localparam int PW  = $clog2(DEPTH);
  localparam int PW1 = PW + 1;
  localparam logic [PW:0] FULL_COUNT = PW1'(DEPTH);

  logic            opcode_ok;
  logic            funct3_ok;
  logic            in_legal;
  logic [XLEN-1:0] rs2_sel;
  logic [6:0]      ctrl_sel;

  logic            req_valid;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [XLEN-1:0] req_rs3;
  logic [6:0]      req_ctrl;

  logic [4:0]      fifo_rd [DEPTH];
  logic [DEPTH-1:0] fifo_ill;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     fifo_count;

  logic            accept;
  logic            issue;
  logic            fifo_empty;
  logic            head_ill;
  logic            wb_free;
  logic            take_result;
  logic            take_illegal;
  logic            pop;
  logic            unused_insn_bits;

  always_comb begin
    opcode_ok = 1'b0;
    case (in_insn[6:0])
      7'b0010011, 7'b0110011, 7'b0011011, 7'b0111011: opcode_ok = 1'b1;
      default:                                         opcode_ok = 1'b0;
    endcase
  end

  assign funct3_ok = (in_insn[14:12] == 3'b001) || (in_insn[14:12] == 3'b101);
  // A word-form shift has no meaning on an RV32 datapath.
  assign in_legal  = opcode_ok && funct3_ok && !((XLEN == 32) && in_insn[3]);
  assign rs2_sel   = in_insn[5] ? in_rs2 : XLEN'(in_insn[25:20]);
  assign ctrl_sel  = {in_insn[30], in_insn[29], in_insn[27], in_insn[26],
                      in_insn[14], in_insn[12], in_insn[3]};
  assign unused_insn_bits = ^{in_insn[31], in_insn[28], in_insn[19:15]};

  assign fifo_empty   = (fifo_count == '0);
  assign head_ill     = fifo_ill[rd_ptr];
  assign wb_free      = !wb_valid || wb_ready;

  assign in_ready     = (fifo_count < FULL_COUNT) && (!req_valid || unit_ready);
  assign accept       = in_valid && in_ready;
  assign issue        = req_valid && unit_ready;

  assign unit_dout_ready = wb_free && !fifo_empty && !head_ill;
  assign take_result     = unit_dout_valid && unit_dout_ready;
  assign take_illegal    = wb_free && !fifo_empty && head_ill;
  assign pop             = take_result || take_illegal;

  assign unit_valid  = req_valid;
  assign unit_rs1    = req_rs1;
  assign unit_rs2    = req_rs2;
  assign unit_rs3    = req_rs3;
  assign unit_insn3  = req_ctrl[0];
  assign unit_insn12 = req_ctrl[1];
  assign unit_insn14 = req_ctrl[2];
  assign unit_insn26 = req_ctrl[3];
  assign unit_insn27 = req_ctrl[4];
  assign unit_insn29 = req_ctrl[5];
  assign unit_insn30 = req_ctrl[6];

  // Request register; only loads when empty or draining, so a stalled request never changes.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      req_valid <= 1'b0;
      req_rs1   <= '0;
      req_rs2   <= '0;
      req_rs3   <= '0;
      req_ctrl  <= '0;
    end else if (accept && in_legal) begin
      req_valid <= 1'b1;
      req_rs1   <= in_rs1;
      req_rs2   <= rs2_sel;
      req_rs3   <= in_rs3;
      req_ctrl  <= ctrl_sel;
    end else if (issue) begin
      req_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      fifo_rd[wr_ptr]  <= in_insn[11:7];
      fifo_ill[wr_ptr] <= !in_legal;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Writeback register; illegal heads complete here without ever touching the unit.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wb_valid   <= 1'b0;
      wb_rd_idx  <= '0;
      wb_value   <= '0;
      wb_illegal <= 1'b0;
    end else if (pop) begin
      wb_valid   <= 1'b1;
      wb_rd_idx  <= fifo_rd[rd_ptr];
      wb_value   <= take_result ? unit_dout_rd : '0;
      wb_illegal <= take_illegal;
    end else if (wb_ready) begin
      wb_valid   <= 1'b0;
    end
  end

`ifdef RVB_SHIFTER_ISSUE_PERF_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      perf_issued  <= '0;
      perf_illegal <= '0;
      perf_stall   <= '0;
    end else begin
      if (issue)                 perf_issued  <= perf_issued + 32'd1;
      if (accept && !in_legal)   perf_illegal <= perf_illegal + 32'd1;
      if (in_valid && !in_ready) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
